// File: rtl/pix_io_pkg.sv
// Shared widths, colour/index types and button slot numbers for the pixel front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pix_io_pkg;

    localparam int CHANW = 4;
    localparam int COLRW = 3 * CHANW;
    localparam int CIDXW = 4;

    typedef logic [COLRW-1:0] colr_t;
    typedef logic [CIDXW-1:0] cidx_t;

    // Bit positions of each button in btn_in / btn_out / btn_ondn / btn_onup.
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_UP    = 2;

endpackage

// File: rtl/btn_debounce.sv
// Single-button synchroniser + debouncer with press/release pulses.
// Latency: output follows a stable input change 2**DEB_CNTW + 2 cycles after it is first sampled.
// Backpressure: none; free-running every clk_pix cycle.
//
// Ports: clk_pix/rst_pix clock and async active-high reset; in raw async button;
//        out debounced level; ondn/onup one-cycle press/release pulses.
module btn_debounce #(
    parameter int DEB_CNTW = 16
) (
    input  logic clk_pix,
    input  logic rst_pix,
    input  logic in,
    output logic out,
    output logic ondn,
    output logic onup
);

    logic                s1;
    logic                s2;
    logic [DEB_CNTW-1:0] cnt;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end

    // The counter only runs while the synchronised input disagrees with the
    // current output; any agreement (i.e. a bounce back) restarts the wait.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            cnt  <= '0;
            out  <= 1'b0;
            ondn <= 1'b0;
            onup <= 1'b0;
        end else begin
            ondn <= 1'b0;
            onup <= 1'b0;
            if (s2 == out) begin
                cnt <= '0;
            end else if (cnt == '1) begin
                cnt  <= '0;
                out  <= s2;
                ondn <= s2;
                onup <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pix_io_frontend.sv
// Pixel-domain front end: lock-derived reset, three button debouncers, writable colour LUT.
// Latency: rst_sys 3 cycles from lock change; buttons 2**DEB_CNTW+2; CLUT read 1 cycle, read-first.
// Backpressure: none; all paths accept a new input every clk_pix cycle.
//
// Ports: clk_pix/rst_pix clock and async active-high reset; clk_locked -> rst_sys;
//        btn_in {up,left,right} -> btn_out/btn_ondn/btn_onup;
//        we/cidx_write/colr_in CLUT write port; cidx_read -> colr_out registered read.
module pix_io_frontend
    import pix_io_pkg::*;
#(
    parameter int    CHANW    = pix_io_pkg::CHANW,
    parameter int    COLRW    = 3 * CHANW,
    parameter int    CIDXW    = pix_io_pkg::CIDXW,
    parameter string PAL_FILE = "",
    parameter int    DEB_CNTW = 16
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             clk_locked,
    output logic             rst_sys,
    input  logic [2:0]       btn_in,
    output logic [2:0]       btn_out,
    output logic [2:0]       btn_ondn,
    output logic [2:0]       btn_onup,
    input  logic             we,
    input  logic [CIDXW-1:0] cidx_write,
    input  logic [COLRW-1:0] colr_in,
    input  logic [CIDXW-1:0] cidx_read,
    output logic [COLRW-1:0] colr_out
);

    localparam int DEPTH = 2 ** CIDXW;

    // ---------------------------------------------------------------
    // Lock -> system reset: 2-flop synchroniser then one output flop.
    // ---------------------------------------------------------------
    logic lock_s1;
    logic lock_s2;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
            rst_sys <= 1'b1;
        end else begin
            lock_s1 <= clk_locked;
            lock_s2 <= lock_s1;
            rst_sys <= ~lock_s2;
        end
    end

    // ---------------------------------------------------------------
    // Button debouncers, one per button, fully independent.
    // ---------------------------------------------------------------
    btn_debounce #(.DEB_CNTW(DEB_CNTW)) u_deb_right (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .in      (btn_in[BTN_RIGHT]),
        .out     (btn_out[BTN_RIGHT]),
        .ondn    (btn_ondn[BTN_RIGHT]),
        .onup    (btn_onup[BTN_RIGHT])
    );

    btn_debounce #(.DEB_CNTW(DEB_CNTW)) u_deb_left (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .in      (btn_in[BTN_LEFT]),
        .out     (btn_out[BTN_LEFT]),
        .ondn    (btn_ondn[BTN_LEFT]),
        .onup    (btn_onup[BTN_LEFT])
    );

    btn_debounce #(.DEB_CNTW(DEB_CNTW)) u_deb_up (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .in      (btn_in[BTN_UP]),
        .out     (btn_out[BTN_UP]),
        .ondn    (btn_ondn[BTN_UP]),
        .onup    (btn_onup[BTN_UP])
    );

    // ---------------------------------------------------------------
    // Colour lookup table. The array has no reset so it can map onto RAM;
    // its power-up contents are all zero.
    // ---------------------------------------------------------------
    logic [COLRW-1:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (we) begin
            mem[cidx_write] <= colr_in;
        end
    end

    // Read samples the pre-edge array contents, so a same-address write in
    // the same cycle is seen only by the following read (read-first).
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            colr_out <= '0;
        end else begin
            colr_out <= mem[cidx_read];
        end
    end

endmodule

// File: tb/tb_pix_io_frontend.sv
module tb_pix_io_frontend;

    logic        clk_pix = 1'b0;
    logic        rst_pix;
    logic        clk_locked;
    logic        rst_sys;
    logic [2:0]  btn_in;
    logic [2:0]  btn_out;
    logic [2:0]  btn_ondn;
    logic [2:0]  btn_onup;
    logic        we;
    logic [3:0]  cidx_write;
    logic [11:0] colr_in;
    logic [3:0]  cidx_read;
    logic [11:0] colr_out;

    int total = 0;
    int bad   = 0;

    always #5 clk_pix = ~clk_pix;

    pix_io_frontend #(
        .CHANW    (4),
        .COLRW    (12),
        .CIDXW    (4),
        .PAL_FILE (""),
        .DEB_CNTW (2)
    ) dut (
        .clk_pix    (clk_pix),
        .rst_pix    (rst_pix),
        .clk_locked (clk_locked),
        .rst_sys    (rst_sys),
        .btn_in     (btn_in),
        .btn_out    (btn_out),
        .btn_ondn   (btn_ondn),
        .btn_onup   (btn_onup),
        .we         (we),
        .cidx_write (cidx_write),
        .colr_in    (colr_in),
        .cidx_read  (cidx_read),
        .colr_out   (colr_out)
    );

    typedef struct {
        logic        we;
        logic [3:0]  widx;
        logic [11:0] wdat;
        logic [3:0]  ridx;
        logic [11:0] exp;
    } clut_vec_t;

    clut_vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One rising edge, then sample on the falling edge.
    task automatic tick();
        @(posedge clk_pix);
        @(negedge clk_pix);
    endtask

    initial begin
        logic [11:0] hold_exp;
        logic        bpat [12];

        // Each CLUT row is applied, then colr_out is checked after one edge.
        // Memory starts all-zero because no palette file is given.
        tbl[0] = '{1'b1, 4'd4,  12'h27D, 4'd4,  12'h000};
        tbl[1] = '{1'b1, 4'd11, 12'hABC, 4'd4,  12'h27D};
        tbl[2] = '{1'b0, 4'd0,  12'h000, 4'd11, 12'hABC};
        tbl[3] = '{1'b1, 4'd3,  12'h123, 4'd0,  12'h000};
        tbl[4] = '{1'b1, 4'd3,  12'h456, 4'd3,  12'h123};
        tbl[5] = '{1'b0, 4'd0,  12'h000, 4'd3,  12'h456};
        tbl[6] = '{1'b1, 4'd0,  12'hFFF, 4'd11, 12'hABC};
        tbl[7] = '{1'b0, 4'd0,  12'h000, 4'd0,  12'hFFF};
        tbl[8] = '{1'b0, 4'd0,  12'h000, 4'd15, 12'h000};

        // Bounce pattern on the up button: 1,1,0,0 then held 1 (edges 1..12).
        for (int i = 0; i < 12; i++) bpat[i] = (i == 2 || i == 3) ? 1'b0 : 1'b1;

        rst_pix    = 1'b1;
        clk_locked = 1'b0;
        btn_in     = 3'b000;
        we         = 1'b0;
        cidx_write = '0;
        colr_in    = '0;
        cidx_read  = '0;
        #1;
        check("reset_rst_sys",  32'(rst_sys),  32'd1);
        check("reset_btn_out",  32'(btn_out),  32'd0);
        check("reset_btn_ondn", 32'(btn_ondn), 32'd0);
        check("reset_btn_onup", 32'(btn_onup), 32'd0);
        check("reset_colr_out", 32'(colr_out), 32'd0);

        @(negedge clk_pix);
        rst_pix = 1'b0;

        // Lock held low: rst_sys must stay asserted.
        for (int k = 0; k < 8; k++) begin
            tick();
            check("unlocked_rst_sys", 32'(rst_sys), 32'd1);
        end

        // Lock rises before edge 1: still 1 after edges 1,2; 0 from edge 3.
        clk_locked = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("lock_rst_sys_e%0d", k), 32'(rst_sys), (k >= 3) ? 32'd0 : 32'd1);
        end

        // Async reset mid-run forces rst_sys at once, then lock re-syncs.
        rst_pix = 1'b1;
        #1;
        check("async_rst_sys", 32'(rst_sys), 32'd1);
        @(negedge clk_pix);
        rst_pix = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("relock_rst_sys_e%0d", k), 32'(rst_sys), (k >= 3) ? 32'd0 : 32'd1);
        end

        // Lock loss: rst_sys rises 3 edges later.
        clk_locked = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("unlock_rst_sys_e%0d", k), 32'(rst_sys), (k >= 3) ? 32'd1 : 32'd0);
        end
        clk_locked = 1'b1;

        // CLUT table.
        for (int i = 0; i < 9; i++) begin
            we         = tbl[i].we;
            cidx_write = tbl[i].widx;
            colr_in    = tbl[i].wdat;
            cidx_read  = tbl[i].ridx;
            tick();
            check($sformatf("clut_row%0d", i), 32'(colr_out), 32'(tbl[i].exp));
        end
        we = 1'b0;

        // Read port must hold its value with a steady index (0 holds FFF).
        cidx_read = 4'd0;
        hold_exp  = 12'hFFF;
        tick();
        tick();
        check("clut_hold", 32'(colr_out), 32'(hold_exp));

        // Clean press on right: out rises and ondn pulses at edge 6 only.
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("press_out_e%0d", k),  32'(btn_out),  (k >= 6) ? 32'd1 : 32'd0);
            check($sformatf("press_ondn_e%0d", k), 32'(btn_ondn), (k == 6) ? 32'd1 : 32'd0);
            check($sformatf("press_onup_e%0d", k), 32'(btn_onup), 32'd0);
        end

        // Release: onup pulses at edge 6 only.
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("rel_out_e%0d", k),  32'(btn_out),  (k >= 6) ? 32'd0 : 32'd1);
            check($sformatf("rel_onup_e%0d", k), 32'(btn_onup), (k == 6) ? 32'd1 : 32'd0);
            check($sformatf("rel_ondn_e%0d", k), 32'(btn_ondn), 32'd0);
        end

        // Bounce on up: the final stable 1 starts at edge 5, so one ondn at edge 10.
        for (int k = 1; k <= 12; k++) begin
            btn_in[2] = bpat[k-1];
            tick();
            check($sformatf("bounce_out_e%0d", k),  32'(btn_out),  (k >= 10) ? 32'd4 : 32'd0);
            check($sformatf("bounce_ondn_e%0d", k), 32'(btn_ondn), (k == 10) ? 32'd4 : 32'd0);
            check($sformatf("bounce_onup_e%0d", k), 32'(btn_onup), 32'd0);
        end

        // Simultaneous right+left press with up still held.
        btn_in = 3'b111;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("simul_out_e%0d", k),  32'(btn_out),  (k >= 6) ? 32'd7 : 32'd4);
            check($sformatf("simul_ondn_e%0d", k), 32'(btn_ondn), (k == 6) ? 32'd3 : 32'd0);
        end

        // Release everything and let it settle.
        btn_in = 3'b000;
        for (int k = 0; k < 8; k++) tick();
        check("all_released", 32'(btn_out), 32'd0);

        // Reset mid-debounce: left counter reaches 2 after edge 4.
        btn_in[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("middeb_no_pulse", 32'(btn_ondn), 32'd0);
        end
        rst_pix = 1'b1;
        #1;
        check("middeb_rst_out",  32'(btn_out),  32'd0);
        check("middeb_rst_ondn", 32'(btn_ondn), 32'd0);
        tick();
        check("middeb_rst_hold_out", 32'(btn_out), 32'd0);
        rst_pix = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("redeb_out_e%0d", k),  32'(btn_out),  (k >= 6) ? 32'd2 : 32'd0);
            check($sformatf("redeb_ondn_e%0d", k), 32'(btn_ondn), (k == 6) ? 32'd2 : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
